// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hsync/vsync/data-enable and pixel coordinates from one pixel clock.
// Runs whole frames only; en is sampled in IDLE and at the last pixel of each frame.
module vga_timing_gen #(
    parameter int H_ACTIVE           = 640,
    parameter int H_FRONT_PORCH      = 16,
    parameter int HSYNC_PULSE_CYCLES = 96,
    parameter int H_BACK_PORCH       = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FRONT_PORCH      = 10,
    parameter int VSYNC_PULSE_LINES  = 2,
    parameter int V_BACK_PORCH       = 33,
    parameter int COORD_W            = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               data,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + HSYNC_PULSE_CYCLES + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + VSYNC_PULSE_LINES + V_BACK_PORCH;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_FP_START   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_BP_START   = HW'(H_ACTIVE + H_FRONT_PORCH + HSYNC_PULSE_CYCLES);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_FP_START   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_BP_START   = VW'(V_ACTIVE + V_FRONT_PORCH + VSYNC_PULSE_LINES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    state_t        state;
    state_t        state_n;
    logic [HW-1:0] h;
    logic [HW-1:0] h_n;
    logic [VW-1:0] v;
    logic [VW-1:0] v_n;
    phase_t        h_ph;
    phase_t        v_ph;

    function automatic phase_t h_phase(input logic [HW-1:0] x);
        if (x < H_FP_START)        return PH_ACTIVE;
        else if (x < H_SYNC_START) return PH_FRONT;
        else if (x < H_BP_START)   return PH_SYNC;
        else                       return PH_BACK;
    endfunction

    function automatic phase_t v_phase(input logic [VW-1:0] y);
        if (y < V_FP_START)        return PH_ACTIVE;
        else if (y < V_SYNC_START) return PH_FRONT;
        else if (y < V_BP_START)   return PH_SYNC;
        else                       return PH_BACK;
    endfunction

    always_comb begin
        state_n = state;
        h_n     = h;
        v_n     = v;
        unique case (state)
            IDLE: begin
                h_n = '0;
                v_n = '0;
                if (en) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (h == H_LAST) begin
                    h_n = '0;
                    if (v == V_LAST) begin
                        v_n = '0;
                        if (!en) begin
                            state_n = IDLE;
                        end
                    end else begin
                        v_n = v + VW'(1);
                    end
                end else begin
                    h_n = h + HW'(1);
                end
            end
        endcase
    end

    // Outputs are decoded from the next counter values so they are registered alongside h/v.
    always_comb begin
        h_ph = h_phase(h_n);
        v_ph = v_phase(v_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h           <= '0;
            v           <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            data        <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            state <= state_n;
            h     <= h_n;
            v     <= v_n;
            if (state_n == RUN) begin
                hsync       <= (h_ph != PH_SYNC);
                vsync       <= (v_ph != PH_SYNC);
                data        <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
                col         <= COORD_W'(h_n);
                row         <= COORD_W'(v_n);
                frame_start <= (h_n == '0) && (v_n == '0);
                line_start  <= (h_n == '0);
            end else begin
                hsync       <= 1'b1;
                vsync       <= 1'b1;
                data        <= 1'b0;
                col         <= '0;
                row         <= '0;
                frame_start <= 1'b0;
                line_start  <= 1'b0;
            end
        end
    end

endmodule
